// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: buffered command to single-transfer AHB-Lite master; optional error check via AHB_CMD_MASTER_ERRCHK_EN
module ahb_cmd_master #(
    parameter int AWIDTH    = 10,
    parameter int CMD_DEPTH = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [AWIDTH-1:0] CMD_ADDR,
    input  logic [31:0]       CMD_WDATA,
    input  logic [2:0]        CMD_SIZE,
    output logic              RSP_VALID,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic              HSEL,
    output logic [AWIDTH-1:0] HADDR,
    output logic              HWRITE,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic              HMASTLOCK,
    output logic [3:0]        HPROT,
    output logic [31:0]       HWDATA,
    output logic              HREADYIN,
    input  logic [31:0]       HRDATA,
    input  logic              HREADYOUT,
    input  logic              HRESP
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AWIDTH + 36;
`ifdef AHB_CMD_MASTER_ERRCHK_EN
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR2} state_t;
`else
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    logic unused_hresp;
    assign unused_hresp = HRESP;
    assign RSP_ERR      = 1'b0;
`endif
    state_t        state;
    logic [EW-1:0] mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nx;
    logic [31:0]   cur_wdata;
    logic          push, pop;
    assign push      = CMD_VALID && CMD_READY;
    assign pop       = state == IDLE && count != '0;
    assign count_nx  = count + CW'(push) - CW'(pop);
    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = 4'b0011;
    assign HREADYIN  = HREADYOUT;

    // command storage; a slot's contents only matter while it is occupied
    always_ff @(posedge HCLK)
        if (push) mem[wr_ptr] <= {CMD_WRITE, CMD_SIZE, CMD_ADDR, CMD_WDATA};

    // buffer pointers, occupancy and registered ready (full means not ready)
    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            CMD_READY <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(push);
            rd_ptr    <= rd_ptr + PW'(pop);
            count     <= count_nx;
            CMD_READY <= count_nx != CW'(CMD_DEPTH);
        end

    // transfer sequencer: one address phase, one data phase, one idle gap per command
    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) begin
            state     <= IDLE;
            HSEL      <= 1'b0;
            HTRANS    <= 2'b00;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'b000;
            HWDATA    <= '0;
            cur_wdata <= '0;
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
`ifdef AHB_CMD_MASTER_ERRCHK_EN
            RSP_ERR   <= 1'b0;
`endif
        end else begin
            RSP_VALID <= 1'b0;
            case (state)
                IDLE: if (pop) begin
                    state  <= ADDR;
                    HSEL   <= 1'b1;
                    HTRANS <= 2'b10;
                    {HWRITE, HSIZE, HADDR, cur_wdata} <= mem[rd_ptr];
                end
                ADDR: if (HREADYOUT) begin
                    state  <= DATA;
                    HSEL   <= 1'b0;
                    HTRANS <= 2'b00;
                    HWDATA <= cur_wdata;
                end
`ifdef AHB_CMD_MASTER_ERRCHK_EN
                DATA: if (HRESP && !HREADYOUT) state <= ERR2;
                else if (HREADYOUT) begin
                    state     <= IDLE;
                    RSP_VALID <= 1'b1;
                    RSP_RDATA <= HWRITE ? 32'd0 : HRDATA;
                    RSP_ERR   <= 1'b0;
                end
                ERR2: if (HRESP && HREADYOUT) begin
                    state     <= IDLE;
                    RSP_VALID <= 1'b1;
                    RSP_RDATA <= 32'd0;
                    RSP_ERR   <= 1'b1;
                end
`else
                DATA: if (HREADYOUT) begin
                    state     <= IDLE;
                    RSP_VALID <= 1'b1;
                    RSP_RDATA <= HWRITE ? 32'd0 : HRDATA;
                end
`endif
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_ahb_cmd_master.sv
// tb_ahb_cmd_master: randomized and directed checks of ahb_cmd_master against a transaction-level model
module tb_ahb_cmd_master;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
`ifdef AHB_CMD_MASTER_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic          HCLK = 1'b0, HRESET = 1'b1;
    logic          CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [31:0]   CMD_WDATA = '0;
    logic [2:0]    CMD_SIZE = '0;
    logic          RSP_VALID, RSP_ERR, HSEL, HWRITE, HMASTLOCK, HREADYIN;
    logic [31:0]   RSP_RDATA, HWDATA;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic [31:0]   HRDATA = '0;
    logic          HREADYOUT = 1'b1, HRESP = 1'b0;

    ahb_cmd_master #(.AWIDTH(AW), .CMD_DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_SIZE(CMD_SIZE),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADYIN(HREADYIN), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic          w;
        logic [2:0]    sz;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } cmd_t;

    int            vectors = 0, miscompares = 0;
    cmd_t          q[$];
    cmd_t          cur;
    int            ph = 0;
    bit            exp_ready = 1'b0;
    bit            rsp = 1'b0, rsp_e = 1'b0;
    logic [31:0]   rsp_d = '0;
    int            rsp_cnt = 0;
    logic [AW-1:0] seen_addr[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // advance one clock: update the model from the inputs present at the edge, then compare
    task automatic step();
        cmd_t nc;
        bit   acc;
        acc  = CMD_VALID && exp_ready;
        nc.w = CMD_WRITE; nc.sz = CMD_SIZE; nc.a = CMD_ADDR; nc.d = CMD_WDATA;
        rsp  = 1'b0;
        if (HTRANS == 2'b10 && HREADYOUT) seen_addr.push_back(HADDR);
        case (ph)
            0: if (q.size() > 0) begin cur = q.pop_front(); ph = 1; end
            1: if (HREADYOUT) ph = 2;
            2: if (ERRCHK && HRESP && !HREADYOUT) ph = 3;
               else if (HREADYOUT) begin rsp = 1'b1; rsp_d = cur.w ? 32'd0 : HRDATA; rsp_e = 1'b0; ph = 0; end
            default: if (HRESP && HREADYOUT) begin rsp = 1'b1; rsp_d = 32'd0; rsp_e = 1'b1; ph = 0; end
        endcase
        if (acc) q.push_back(nc);
        exp_ready = q.size() < DEPTH;
        @(posedge HCLK);
        #1;
        if (RSP_VALID) rsp_cnt++;
        chk("cmd_ready", CMD_READY, exp_ready);
        chk("htrans", HTRANS, ph == 1 ? 2'b10 : 2'b00);
        chk("hsel", HSEL, ph == 1);
        chk("rsp_valid", RSP_VALID, rsp);
        chk("const", {HBURST, HMASTLOCK, HPROT, HREADYIN}, {3'b000, 1'b0, 4'b0011, HREADYOUT});
        if (ph == 1) chk("addr_phase", {HWRITE, HSIZE, HADDR}, {cur.w, cur.sz, cur.a});
        if (ph == 2) chk("hwdata", HWDATA, cur.d);
        if (rsp) chk("rsp_data_err", {RSP_ERR, RSP_RDATA}, {rsp_e, rsp_d});
    endtask

    task automatic do_reset();
        CMD_VALID = 1'b0;
        HRESET = 1'b1;
        #1;
        q.delete(); ph = 0; exp_ready = 1'b0; rsp = 1'b0;
        chk("rst_ready", CMD_READY, 0);
        chk("rst_rsp", {RSP_VALID, RSP_ERR, RSP_RDATA}, 0);
        chk("rst_bus", {HSEL, HTRANS, HWRITE, HSIZE}, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwdata", HWDATA, 0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        step();
        chk("ready_after_release", CMD_READY, 1);
    endtask

    task automatic set_cmd(input bit w, input logic [AW-1:0] a, input logic [31:0] d);
        CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = d; CMD_SIZE = 3'b010;
    endtask

    initial begin
        bit done;
        do_reset();

        // single write, slave always ready
        HREADYOUT = 1'b1; HRESP = 1'b0;
        set_cmd(1'b1, 10'h010, 32'hA5A5A5A5);
        step();
        CMD_VALID = 1'b0;
        step();
        chk("wr_nonseq", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b1, 10'h010});
        step();
        chk("wr_data", {HTRANS, HWDATA}, {2'b00, 32'hA5A5A5A5});
        step();
        chk("wr_rsp", {RSP_VALID, RSP_ERR}, 2'b10);
        step();
        chk("wr_rsp_pulse", RSP_VALID, 0);

        // read with two wait states in the data phase
        set_cmd(1'b0, 10'h020, 32'h0);
        step();
        CMD_VALID = 1'b0;
        step();
        chk("rd_nonseq", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b0, 10'h020});
        step();
        HREADYOUT = 1'b0;
        step();
        chk("rd_wait1", RSP_VALID, 0);
        step();
        chk("rd_wait2", RSP_VALID, 0);
        HREADYOUT = 1'b1; HRDATA = 32'h12345678;
        step();
        chk("rd_rsp", {RSP_VALID, RSP_RDATA}, {1'b1, 32'h12345678});
        step();

        // fill the buffer behind a stalled slave, then drain in order
        rsp_cnt = 0; seen_addr.delete();
        HREADYOUT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, AW'(10'h100 + i * 4), 32'(i));
            done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                done = exp_ready;
                step();
            end
            chk("fill_accept", done, 1);
        end
        chk("full_not_ready", CMD_READY, 0);
        CMD_VALID = 1'b0;
        HREADYOUT = 1'b1;
        for (int k = 0; k < 100 && rsp_cnt < 5; k++) step();
        chk("drain_rsp_cnt", rsp_cnt, 5);
        chk("drain_addr_cnt", seen_addr.size(), 5);
        for (int i = 0; i < 5 && i < seen_addr.size(); i++)
            chk("drain_order", seen_addr[i], AW'(10'h100 + i * 4));

        // error response: two-cycle HRESP with the check enabled, plain wait state otherwise
        set_cmd(1'b0, 10'h040, 32'h0);
        step();
        CMD_VALID = 1'b0;
        step();
        step();
        HRESP = 1'b1; HREADYOUT = 1'b0; HRDATA = 32'hDEADBEEF;
        step();
        chk("err_wait", RSP_VALID, 0);
        HREADYOUT = 1'b1;
        step();
        chk("err_rsp", {RSP_VALID, RSP_ERR, RSP_RDATA}, {1'b1, ERRCHK, ERRCHK ? 32'd0 : 32'hDEADBEEF});
        HRESP = 1'b0;
        rsp_cnt = 0;
        set_cmd(1'b1, 10'h044, 32'h55AA55AA);
        step();
        CMD_VALID = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("after_err_rsp_cnt", rsp_cnt, 1);

        // reset during a data phase with commands still queued
        HREADYOUT = 1'b1;
        set_cmd(1'b1, 10'h080, 32'h1);
        step();
        set_cmd(1'b1, 10'h084, 32'h2);
        step();
        set_cmd(1'b0, 10'h088, 32'h3);
        step();
        CMD_VALID = 1'b0; HREADYOUT = 1'b0;
        step();
        chk("pre_reset_in_data", {HTRANS, HWDATA}, {2'b00, 32'h1});
        do_reset();
        rsp_cnt = 0; seen_addr.delete();
        HREADYOUT = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("reset_no_rsp", rsp_cnt, 0);
        chk("reset_no_transfer", seen_addr.size(), 0);

        // randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            CMD_VALID = 1'($urandom_range(0, 1));
            CMD_WRITE = 1'($urandom_range(0, 1));
            CMD_ADDR  = AW'($urandom);
            CMD_WDATA = $urandom;
            CMD_SIZE  = 3'($urandom_range(0, 2));
            HREADYOUT = $urandom_range(0, 9) < 7;
            HRESP     = $urandom_range(0, 4) == 0;
            HRDATA    = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
